// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg : shared types, encodings and helpers for the UART path |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int OVERSAMPLE_DEFAULT = 16;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  function automatic logic [3:0] data_bits(input logic [1:0] wls);
    case (wls)
      WLS_5:   return 4'd5;
      WLS_6:   return 4'd6;
      WLS_7:   return 4'd7;
      WLS_8:   return 4'd8;
      default: return 4'd8;
    endcase
  endfunction

  // Total stop-phase length in baud ticks: 1, 1.5 (5-bit words only) or 2 bits.
  function automatic int unsigned stop_ticks(input logic stb, input logic [1:0] wls,
                                             input int unsigned oversample);
    if (!stb)
      return oversample;
    if (wls == WLS_5)
      return oversample + oversample / 2;
    return 2 * oversample;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_bit_timer : baud-tick counter with programmable bit length   |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module uart_bit_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] terminal,
  output logic             bit_done
);

  logic [CNT_W-1:0] cnt;

  // Fires on the tick that would make the count reach the terminal value.
  assign bit_done = tick && ((cnt + CNT_W'(1)) == terminal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clear || bit_done)
      cnt <= '0;
    else if (tick)
      cnt <= cnt + CNT_W'(1);
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_ctrl : UART16550 transmit sequencer (FIFO -> serial pin)  |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       baud_pulse,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_pop,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       brk,
  output logic       tx,
  output logic       busy,
  output logic       temt
);

  localparam int unsigned    OS_U      = OVERSAMPLE;
  localparam logic [CNT_W-1:0] TERM_BIT  = CNT_W'(OVERSAMPLE);
  localparam logic [CNT_W-1:0] TERM_HALF = CNT_W'(OVERSAMPLE + OVERSAMPLE / 2);

  tx_state_t  state, state_nxt;
  logic [7:0] shift, shift_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [1:0] cfg_wls;
  logic       cfg_stb, cfg_pen, par_bit;
  logic       load, bit_done, tx_nxt, par_load;
  logic       stop_half, stop_two;
  logic [7:0] data_mask;
  logic [CNT_W-1:0] terminal;

  // Parity is resolved once at load time from the bits that will actually be sent.
  assign data_mask = 8'hFF >> (2'd3 - wls);
  assign par_load  = sp  ? ~eps
                   : eps ? ^(fifo_dout & data_mask) : ~^(fifo_dout & data_mask);

  assign stop_half = (stop_ticks(cfg_stb, cfg_wls, OS_U) == OS_U + OS_U / 2);
  assign stop_two  = (stop_ticks(cfg_stb, cfg_wls, OS_U) == 2 * OS_U);
  assign terminal  = (state == STOP && stop_half) ? TERM_HALF : TERM_BIT;

  uart_bit_timer #(
    .CNT_W(CNT_W)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (load),
    .tick     (baud_pulse && (state != IDLE)),
    .terminal (terminal),
    .bit_done (bit_done)
  );

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    load        = 1'b0;
    case (state)
      IDLE: begin
        if (en && !fifo_empty) begin
          load      = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_nxt   = DATA;
          bit_cnt_nxt = 3'd0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_nxt = shift >> 1;
          if ({1'b0, bit_cnt} == data_bits(cfg_wls) - 4'd1) begin
            state_nxt   = cfg_pen ? PARITY : STOP;
            bit_cnt_nxt = 3'd0;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_nxt   = STOP;
          bit_cnt_nxt = 3'd0;
        end
      end
      STOP: begin
        // Two stop bits run as two full bit periods; 1.5 uses one long period.
        if (bit_done) begin
          if (stop_two && bit_cnt == 3'd0) begin
            bit_cnt_nxt = 3'd1;
          end else if (en && !fifo_empty) begin
            load      = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) begin
      shift_nxt   = fifo_dout;
      bit_cnt_nxt = 3'd0;
    end
  end

  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = par_bit;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= 8'd0;
      bit_cnt <= 3'd0;
      cfg_wls <= WLS_5;
      cfg_stb <= 1'b0;
      cfg_pen <= 1'b0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx      <= brk ? 1'b0 : tx_nxt;
      if (load) begin
        cfg_wls <= wls;
        cfg_stb <= stb;
        cfg_pen <= pen;
        par_bit <= par_load;
      end
    end
  end

  assign fifo_pop = load;
  assign busy     = (state != IDLE);
  assign temt     = (state == IDLE) && fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_tx_ctrl : self-checking bench for uart_tx_ctrl            |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, baud_pulse, fifo_empty, fifo_pop;
  logic [7:0] fifo_dout;
  logic [1:0] wls;
  logic       stb, pen, eps, sp, brk;
  logic       tx, busy, temt;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side FIFO: written by the stimulus, drained by the DUT's pop strobe.
  logic [7:0] fifo_mem [0:7];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;
  int pop_empty_err = 0;
  logic [1:0] div = 2'd0;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_dout  = fifo_mem[rd_ptr[2:0]];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    div        <= div + 2'd1;
    baud_pulse <= (div == 2'd3);
  end

  always @(posedge clk) begin
    if (fifo_pop === 1'b1) begin
      pops <= pops + 1;
      if (fifo_empty) pop_empty_err <= pop_empty_err + 1;
      else            rd_ptr <= rd_ptr + 1;
    end
  end

  uart_tx_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .baud_pulse(baud_pulse),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_pop(fifo_pop),
    .wls(wls), .stb(stb), .pen(pen), .eps(eps), .sp(sp), .brk(brk),
    .tx(tx), .busy(busy), .temt(temt)
  );

  typedef struct {
    string      name;
    logic [1:0] wls;
    logic       stb, pen, eps, sp;
    logic [7:0] data;
    logic [11:0] bits;   // start, data, parity; bit i is the i-th bit on the wire
    int         nbits;
    int         stop;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[2:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_baud();
    do @(negedge clk); while (baud_pulse !== 1'b1);
  endtask

  task automatic set_cfg(input logic [1:0] w, input logic s, input logic p,
                         input logic e, input logic k);
    wls = w; stb = s; pen = p; eps = e; sp = k;
  endtask

  task automatic check_frame(input string name, input logic [11:0] bits, input int nbits,
                             input int stop, input bit b2b, input bit exp_temt);
    int   guard = 0;
    logic v = 1'b0;
    int   stable;
    while (tx !== 1'b0 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({name, " start seen"}, int'(tx === 1'b0), 1);
    if (tx !== 1'b0) return;
    for (int i = 0; i < nbits; i++) begin
      stable = 1;
      for (int t = 0; t < 16; t++) begin
        wait_baud();
        if (t == 0) v = tx;
        else if (tx !== v) stable = 0;
      end
      chk($sformatf("%s bit%0d (value+2*stable)", name, i), int'(v) + 2 * stable,
          int'(bits[i]) + 2);
    end
    stable = 1;
    for (int t = 0; t < stop; t++) begin
      wait_baud();
      if (tx !== 1'b1) stable = 0;
    end
    chk({name, " stop high"}, stable, 1);
    chk({name, " busy at last stop tick"}, int'(busy), 1);
    @(posedge clk); #1;
    if (b2b) begin
      chk({name, " next start tx"}, int'(tx), 0);
      chk({name, " next start busy"}, int'(busy), 1);
    end else begin
      chk({name, " idle tx"}, int'(tx), 1);
      chk({name, " idle busy"}, int'(busy), 0);
      chk({name, " temt"}, int'(temt), int'(exp_temt));
    end
  endtask

  initial begin
    int p0, guard, t0;
    int bad_pop, bad_tx, bad_temt;
    rst = 1'b1; en = 1'b0; brk = 1'b0;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

    vecs[0] = '{"8N1 A5",   2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 12'h14A, 9, 16};
    vecs[1] = '{"7E2 41",   2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 8'h41, 12'h082, 9, 32};
    vecs[2] = '{"7O2 41",   2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 8'h41, 12'h182, 9, 32};
    vecs[3] = '{"7S2 41 sp eps0", 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 8'h41, 12'h182, 9, 32};
    vecs[4] = '{"7S2 41 sp eps1", 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 12'h082, 9, 32};
    vecs[5] = '{"5N1.5 1F", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1F, 12'h03E, 6, 24};
    vecs[6] = '{"6O1 2C",   2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h2C, 12'h058, 8, 16};
    vecs[7] = '{"5E1 E3",   2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hE3, 12'h006, 7, 16};

    repeat (3) @(negedge clk);
    chk("reset tx", int'(tx), 1);
    chk("reset fifo_pop", int'(fifo_pop), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset temt", int'(temt), 1);
    rst = 1'b0;
    en  = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[k]) begin
      set_cfg(vecs[k].wls, vecs[k].stb, vecs[k].pen, vecs[k].eps, vecs[k].sp);
      p0 = pops;
      push(vecs[k].data);
      check_frame(vecs[k].name, vecs[k].bits, vecs[k].nbits, vecs[k].stop, 1'b0, 1'b1);
      chk({vecs[k].name, " pops"}, pops - p0, 1);
      repeat (5) @(negedge clk);
    end

    // Back-to-back: second pop lands on the edge the first stop ends.
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    p0 = pops;
    push(8'h00);
    push(8'hFF);
    check_frame("b2b 00", 12'h000, 9, 16, 1'b1, 1'b0);
    chk("b2b pops at first stop end", pops - p0, 2);
    check_frame("b2b FF", 12'h1FE, 9, 16, 1'b0, 1'b1);
    chk("b2b pops total", pops - p0, 2);

    // en dropped mid-frame: frame completes, queued byte stays put.
    repeat (5) @(negedge clk);
    p0 = pops;
    push(8'h3C);
    push(8'h55);
    fork
      check_frame("en drop 3C", 12'h078, 9, 16, 1'b0, 1'b0);
      begin repeat (100) @(negedge clk); en = 1'b0; end
    join
    repeat (300) @(negedge clk);
    chk("en drop pops", pops - p0, 1);
    chk("en drop idle", int'(busy), 0);
    chk("en drop fifo kept", int'(fifo_empty), 0);
    wr_ptr = rd_ptr;
    en = 1'b1;
    repeat (5) @(negedge clk);

    // Reset mid-DATA aborts at once.
    p0 = pops;
    push(8'hAA);
    repeat (250) @(negedge clk);
    chk("pre-rst busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rst mid tx", int'(tx), 1);
    chk("rst mid busy", int'(busy), 0);
    chk("rst mid pop", int'(fifo_pop), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("rst byte lost pops", pops - p0, 1);
    chk("rst after temt", int'(temt), 1);
    chk("rst after tx", int'(tx), 1);

    // Break forces the pin low without disturbing frame timing.
    p0 = pops;
    push(8'hFF);
    guard = 0;
    while (tx !== 1'b0 && guard < 300) begin @(posedge clk); #1; guard++; end
    chk("brk frame start", int'(tx), 0);
    t0 = 0;
    repeat (200) @(negedge clk);
    brk = 1'b1;
    repeat (2) @(negedge clk);
    chk("brk tx low", int'(tx), 0);
    chk("brk busy", int'(busy), 1);
    repeat (40) @(negedge clk);
    brk = 1'b0;
    repeat (2) @(negedge clk);
    chk("brk released tx", int'(tx), 1);
    t0 = 244;
    guard = 0;
    while (busy === 1'b1 && guard < 2000) begin @(negedge clk); guard++; end
    chk("brk frame ends", int'(busy), 0);
    chk("brk frame length ok", int'((t0 + guard) >= 636 && (t0 + guard) <= 646), 1);
    chk("brk pops", pops - p0, 1);

    // Empty FIFO with en=1: nothing happens.
    bad_pop = 0; bad_tx = 0; bad_temt = 0;
    for (int i = 0; i < 420; i++) begin
      @(negedge clk);
      if (fifo_pop !== 1'b0) bad_pop++;
      if (tx !== 1'b1) bad_tx++;
      if (temt !== 1'b1) bad_temt++;
    end
    chk("empty no pop", bad_pop, 0);
    chk("empty tx high", bad_tx, 0);
    chk("empty temt", bad_temt, 0);

    // Config toggled mid-frame has no effect on the frame in flight.
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push(8'hA5);
    fork
      check_frame("cfg toggle A5", 12'h14A, 9, 16, 1'b0, 1'b1);
      begin repeat (150) @(negedge clk); set_cfg(2'b00, 1'b1, 1'b1, 1'b1, 1'b1); end
    join
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);

    chk("no pop while empty", pop_empty_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
